alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal 8..64, power of two).
REQ-002 Parameter: SHW, default $clog2(WIDTH), derived shift-amount width; not overridden.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  request; sampled only in IDLE.
REQ-006 Opcode  in  8  operation, encodings from the shared opcode include.
REQ-007 A, B  in  WIDTH each  operands, latched on accepted Start.
REQ-008 Busy  out  1  high while an operation is in progress.
REQ-009 Done  out  1  one-cycle pulse when C/flags are updated.
REQ-010 C  out  WIDTH  registered result.
REQ-011 Carry, Flag, Low, Negative, Zero  out  1 each  registered status flags.

Function
REQ-012 FSM SHALL have states IDLE, SHIFT, MUL; IDLE + Start accepts the request, latches A, B, Opcode.
REQ-013 Start while Busy SHALL be ignored; no queueing.
REQ-014 Single-cycle ops SHALL update C/flags at the accepting edge, Done high the following cycle, Busy never asserted.
REQ-015 ADD/ADDI: C=A+B mod 2^WIDTH; Flag=signed overflow; Zero=(C==0); Carry, Low, Negative=0.
REQ-016 ADDU/ADDUI: {Carry,C}=A+B; Zero=(C==0); Flag, Low, Negative=0.
REQ-017 ADDCU/ADDCUI: {Carry,C}=A+B+registered Carry flag (value before this op); Zero=(C==0); others 0.
REQ-018 SUB/SUBI: C=A-B; Flag=(A[msb]!=B[msb])&(C[msb]!=A[msb]); Low=unsigned A<B; Negative=signed A<B; Zero=(A==B); Carry=0.
REQ-019 CMP/CMPI: flags as SUB; C unchanged.
REQ-020 AND/OR/XOR/NOT(~A): C=result; Zero=(A==B), Low, Negative as CMP; Flag, Carry=0.
REQ-021 LSH/LSHI/RSH/RSHI/ALSH/ARSH: n=B (unsigned); n=0 -> C=A; n>=WIDTH -> C=0 (ARSH: all bits = A[msb]); both complete single-cycle.
REQ-022 Shifts with 0<n<WIDTH SHALL enter SHIFT, shift one bit per cycle, Busy high, result/flags written after exactly n cycles in SHIFT, Done the next cycle, return to IDLE.
REQ-023 Shift flags: Zero=(C==0); Carry, Flag, Low, Negative=0.
REQ-024 NOP: C and flags unchanged, Done pulses.
REQ-025 Undefined opcode: C=0, all flags 0, Done pulses.
REQ-026 C and flags SHALL hold between operations.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, C=0, all flags 0, Busy=0, Done=0, aborting any in-flight op with no Done.
REQ-028 First Start SHALL be accepted on the first rising edge after reset_n release.

Configuration
REQ-029 Macro ALU_MULTICYCLE_MUL_EN defined: MUL opcode accepted; enters MUL, shift-add one bit per cycle, Busy high, C=low WIDTH bits of A*B after WIDTH cycles, Carry=1 iff high half nonzero, Zero=(C==0), others 0.
REQ-030 Macro undefined: MUL treated as undefined opcode (REQ-025); no MUL state/datapath synthesised.

Verification
REQ-031 WIDTH=16: ADD A=0x7FFF B=0x0001 -> C=0x8000, Flag=1, Zero=0, Done 1 cycle later, Busy never high.
REQ-032 ADDU A=0xFFFF B=0x0001 -> C=0, Carry=1, Zero=1; then ADDCU A=0 B=0 -> C=0x0001, Carry=0.
REQ-033 LSH A=0x0001 B=5 -> Busy high 5 cycles, C=0x0020, Done pulse; Start during Busy ignored; ARSH A=0x8000 B=20 -> C=0xFFFF single-cycle.
REQ-034 SUB A=0x0001 B=0x0002 -> C=0xFFFF, Low=1, Negative=1, Zero=0; CMP A=5 B=5 -> Zero=1, C unchanged.
REQ-035 reset_n low mid-shift (RSH B=10, cycle 4) -> outputs 0 immediately, no Done; next Start accepted after release.
REQ-036 With ALU_MULTICYCLE_MUL_EN: MUL A=0x0100 B=0x0100 -> C=0, Carry=1, Zero=1 after 16 cycles; without: C=0, flags 0, single-cycle.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if -- request/result bundle for alu_multicycle.
//
// Signals:
//   Start, Opcode[7:0], A, B      requester -> ALU
//   Busy, Done, C                 ALU -> requester
//   Carry, Flag, Low, Negative,
//   Zero                          ALU -> requester (status flags)
// Modports: master (requester side), slave (ALU side).

interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [7:0]       Opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] C;
  logic             Carry;
  logic             Flag;
  logic             Low;
  logic             Negative;
  logic             Zero;

  modport master (
    output Start, Opcode, A, B,
    input  Busy, Done, C, Carry, Flag, Low, Negative, Zero
  );

  modport slave (
    input  Start, Opcode, A, B,
    output Busy, Done, C, Carry, Flag, Low, Negative, Zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle -- multi-cycle ALU with registered result and status flags.
//
// Most operations finish at the accepting edge. Shifts by 0 < n < WIDTH walk
// one bit per cycle in SHIFT. The optional MUL op runs shift-add in MUL for
// WIDTH cycles.
//
// Optional feature macro: ALU_MULTICYCLE_MUL_EN (defined = MUL opcode supported;
// undefined = MUL decodes as an undefined opcode and no multiplier exists).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_multicycle_if.slave
//              Start, Opcode[7:0], A, B             in
//              Busy, Done, C, Carry, Flag,
//              Low, Negative, Zero                  out
//
// Opcode encodings live in alu_multicycle_pkg below.

package alu_multicycle_pkg;
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_ADDI   = 8'h02;
  localparam logic [7:0] OP_ADDU   = 8'h03;
  localparam logic [7:0] OP_ADDUI  = 8'h04;
  localparam logic [7:0] OP_ADDCU  = 8'h05;
  localparam logic [7:0] OP_ADDCUI = 8'h06;
  localparam logic [7:0] OP_SUB    = 8'h07;
  localparam logic [7:0] OP_SUBI   = 8'h08;
  localparam logic [7:0] OP_CMP    = 8'h09;
  localparam logic [7:0] OP_CMPI   = 8'h0A;
  localparam logic [7:0] OP_AND    = 8'h0B;
  localparam logic [7:0] OP_OR     = 8'h0C;
  localparam logic [7:0] OP_XOR    = 8'h0D;
  localparam logic [7:0] OP_NOT    = 8'h0E;
  localparam logic [7:0] OP_LSH    = 8'h0F;
  localparam logic [7:0] OP_LSHI   = 8'h10;
  localparam logic [7:0] OP_RSH    = 8'h11;
  localparam logic [7:0] OP_RSHI   = 8'h12;
  localparam logic [7:0] OP_ALSH   = 8'h13;
  localparam logic [7:0] OP_ARSH   = 8'h14;
  localparam logic [7:0] OP_MUL    = 8'h15;
endpackage

module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_multicycle_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

`ifdef ALU_MULTICYCLE_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [MSB:0]     work_q, work_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [MSB:0]     c_q, c_d;
  logic             carry_q, carry_d, flag_q, flag_d, low_q, low_d;
  logic             neg_q, neg_d, zero_q, zero_d, done_q, done_d;
`ifdef ALU_MULTICYCLE_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nxt;
`endif

  logic [WIDTH:0]   add_s, addc_s;
  logic [MSB:0]     diff, shifted;
  logic             add_ovf, sub_ovf, lt_u, lt_s, eq, b_big;

  assign add_s   = {1'b0, bus.A} + {1'b0, bus.B};
  assign addc_s  = add_s + {{WIDTH{1'b0}}, carry_q};
  assign diff    = bus.A - bus.B;
  assign add_ovf = (bus.A[MSB] == bus.B[MSB]) & (add_s[MSB] != bus.A[MSB]);
  assign sub_ovf = (bus.A[MSB] != bus.B[MSB]) & (diff[MSB] != bus.A[MSB]);
  assign lt_u    = bus.A < bus.B;
  assign lt_s    = $signed(bus.A) < $signed(bus.B);
  assign eq      = bus.A == bus.B;
  // any bit at or above SHW set means shift amount >= WIDTH
  assign b_big   = |(bus.B >> SHW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
      low_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
      low_q   <= low_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
`ifdef ALU_MULTICYCLE_MUL_EN
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    flag_d  = flag_q;
    low_d   = low_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    shifted = work_q;
`ifdef ALU_MULTICYCLE_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    acc_nxt = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          op_d    = bus.Opcode;
          done_d  = 1'b1;
          carry_d = 1'b0;
          flag_d  = 1'b0;
          low_d   = 1'b0;
          neg_d   = 1'b0;
          zero_d  = 1'b0;
          case (bus.Opcode)
            OP_NOP: begin
              carry_d = carry_q;
              flag_d  = flag_q;
              low_d   = low_q;
              neg_d   = neg_q;
              zero_d  = zero_q;
            end
            OP_ADD, OP_ADDI: begin
              c_d    = add_s[MSB:0];
              flag_d = add_ovf;
              zero_d = (add_s[MSB:0] == '0);
            end
            OP_ADDU, OP_ADDUI: begin
              c_d     = add_s[MSB:0];
              carry_d = add_s[WIDTH];
              zero_d  = (add_s[MSB:0] == '0);
            end
            OP_ADDCU, OP_ADDCUI: begin
              c_d     = addc_s[MSB:0];
              carry_d = addc_s[WIDTH];
              zero_d  = (addc_s[MSB:0] == '0);
            end
            OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: begin
              if (bus.Opcode == OP_SUB || bus.Opcode == OP_SUBI) c_d = diff;
              flag_d = sub_ovf;
              low_d  = lt_u;
              neg_d  = lt_s;
              zero_d = eq;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              case (bus.Opcode)
                OP_AND:  c_d = bus.A & bus.B;
                OP_OR:   c_d = bus.A | bus.B;
                OP_XOR:  c_d = bus.A ^ bus.B;
                default: c_d = ~bus.A;
              endcase
              low_d  = lt_u;
              neg_d  = lt_s;
              zero_d = eq;
            end
            OP_LSH, OP_LSHI, OP_RSH, OP_RSHI, OP_ALSH, OP_ARSH: begin
              if (bus.B == '0) begin
                c_d    = bus.A;
                zero_d = (bus.A == '0);
              end else if (b_big) begin
                c_d    = (bus.Opcode == OP_ARSH) ? {WIDTH{bus.A[MSB]}} : '0;
                zero_d = (bus.Opcode == OP_ARSH) ? ~bus.A[MSB] : 1'b1;
              end else begin
                state_d = SHIFT;
                done_d  = 1'b0;
                work_d  = bus.A;
                cnt_d   = {1'b0, bus.B[SHW-1:0]};
              end
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            OP_MUL: begin
              state_d = MUL;
              done_d  = 1'b0;
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, bus.A};
              work_d  = bus.B;
              cnt_d   = MUL_CNT;
            end
`endif
            default: c_d = '0;
          endcase
          // multi-cycle ops leave the visible flags alone until they finish
          if (!done_d) begin
            carry_d = carry_q;
            flag_d  = flag_q;
            low_d   = low_q;
            neg_d   = neg_q;
            zero_d  = zero_q;
          end
        end
      end

      SHIFT: begin
        if (op_q == OP_LSH || op_q == OP_LSHI || op_q == OP_ALSH)
          shifted = {work_q[MSB-1:0], 1'b0};
        else if (op_q == OP_ARSH)
          shifted = {work_q[MSB], work_q[MSB:1]};
        else
          shifted = {1'b0, work_q[MSB:1]};
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
          c_d     = shifted;
          carry_d = 1'b0;
          flag_d  = 1'b0;
          low_d   = 1'b0;
          neg_d   = 1'b0;
          zero_d  = (shifted == '0);
        end
      end

`ifdef ALU_MULTICYCLE_MUL_EN
      MUL: begin
        acc_nxt = work_q[0] ? (acc_q + mcand_q) : acc_q;
        acc_d   = acc_nxt;
        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
        work_d  = {1'b0, work_q[MSB:1]};
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
          c_d     = acc_nxt[MSB:0];
          carry_d = |acc_nxt[2*WIDTH-1:WIDTH];
          flag_d  = 1'b0;
          low_d   = 1'b0;
          neg_d   = 1'b0;
          zero_d  = (acc_nxt[MSB:0] == '0);
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = done_q;
  assign bus.C        = c_q;
  assign bus.Carry    = carry_q;
  assign bus.Flag     = flag_q;
  assign bus.Low      = low_q;
  assign bus.Negative = neg_q;
  assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=16): directed cases plus random ops,
// expected responses queued at issue time and checked by a Done-driven monitor.

module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [7:0]   op;
    logic [W-1:0] c;
    logic         carry;
    logic         flag;
    logic         low;
    logic         neg;
    logic         zero;
  } resp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  resp_t exp_q[$];
  resp_t m;

  logic [7:0] op_tab [23] = '{OP_NOP, OP_ADD, OP_ADDI, OP_ADDU, OP_ADDUI, OP_ADDCU,
                              OP_ADDCUI, OP_SUB, OP_SUBI, OP_CMP, OP_CMPI, OP_AND,
                              OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_LSHI, OP_RSH,
                              OP_RSHI, OP_ALSH, OP_ARSH, OP_MUL, 8'hF0};

  // Reference model: arithmetic on 64-bit integers, tracking the architectural
  // result/flag state across operations.
  task automatic model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output resp_t r, output int lat);
    longint ua, ub, sa, sb, s, mask, half;
    int n;
    ua   = longint'(a);
    ub   = longint'(b);
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    n    = (ub > 40) ? 40 : int'(ub);
    r = m;
    r.carry = 1'b0; r.flag = 1'b0; r.low = 1'b0; r.neg = 1'b0; r.zero = 1'b0;
    lat = 1;
    case (op)
      OP_NOP: r = m;
      OP_ADD, OP_ADDI: begin
        s = ua + ub;
        r.c = s[W-1:0];
        r.flag = ((sa + sb) >= half) || ((sa + sb) < -half);
        r.zero = (s & mask) == 0;
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        s = ua + ub;
        if (op == OP_ADDCU || op == OP_ADDCUI) s = s + (m.carry ? 1 : 0);
        r.c = s[W-1:0];
        r.carry = (s >> W) != 0;
        r.zero = (s & mask) == 0;
      end
      OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: begin
        s = ua - ub;
        if (op == OP_SUB || op == OP_SUBI) r.c = s[W-1:0];
        r.flag = ((sa - sb) >= half) || ((sa - sb) < -half);
        r.low  = ua < ub;
        r.neg  = sa < sb;
        r.zero = ua == ub;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        if (op == OP_AND) r.c = a & b;
        else if (op == OP_OR) r.c = a | b;
        else if (op == OP_XOR) r.c = a ^ b;
        else r.c = ~a;
        r.low  = ua < ub;
        r.neg  = sa < sb;
        r.zero = ua == ub;
      end
      OP_LSH, OP_LSHI, OP_ALSH, OP_RSH, OP_RSHI, OP_ARSH: begin
        if (op == OP_RSH || op == OP_RSHI) s = ua >> n;
        else if (op == OP_ARSH) s = sa >>> n;
        else s = ua << n;
        s = s & mask;
        r.c = s[W-1:0];
        r.zero = s == 0;
        if (ub > 0 && ub < W) lat = n + 1;
      end
`ifdef ALU_MULTICYCLE_MUL_EN
      OP_MUL: begin
        s = ua * ub;
        r.c = s[W-1:0];
        r.carry = (s >> W) != 0;
        r.zero = (s & mask) == 0;
        lat = W + 1;
      end
`endif
      default: r.c = '0;
    endcase
    r.op = op;
    m = r;
  endtask

  // Drives Start at the current time (caller is at a negedge), then waits for Done.
  task automatic run_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    resp_t r;
    int exp_lat, lat, busy_n;
    model(op, a, b, r, exp_lat);
    exp_q.push_back(r);
    bus.Start = 1'b1; bus.Opcode = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus.Done && lat < 100) begin
      if (bus.Busy) busy_n++;
      bus.Start = inject && (lat == 2);
      if (bus.Start) begin
        bus.Opcode = OP_ADD; bus.A = W'($urandom); bus.B = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    n_checks++;
    if (lat == exp_lat && busy_n == exp_lat - 1) n_pass++;
    else $display("FAIL timing op=%h got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                  op, lat, busy_n, exp_lat, exp_lat - 1);
  endtask

  // Monitor: every Done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && bus.Done) begin
      resp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp unexpected Done got c=%h", bus.C);
      end else begin
        e = exp_q.pop_front();
        if (bus.C == e.c && bus.Carry == e.carry && bus.Flag == e.flag &&
            bus.Low == e.low && bus.Negative == e.neg && bus.Zero == e.zero)
          n_pass++;
        else
          $display("FAIL resp op=%h got c=%h cy=%b fl=%b lo=%b ng=%b z=%b expected c=%h cy=%b fl=%b lo=%b ng=%b z=%b",
                   e.op, bus.C, bus.Carry, bus.Flag, bus.Low, bus.Negative, bus.Zero,
                   e.c, e.carry, e.flag, e.low, e.neg, e.zero);
      end
    end
  end

  task automatic check_cleared(input string name);
    n_checks++;
    if (bus.C == '0 && !bus.Carry && !bus.Flag && !bus.Low && !bus.Negative &&
        !bus.Zero && !bus.Busy && !bus.Done)
      n_pass++;
    else
      $display("FAIL %s got c=%h cy=%b fl=%b lo=%b ng=%b z=%b busy=%b done=%b expected all zero",
               name, bus.C, bus.Carry, bus.Flag, bus.Low, bus.Negative, bus.Zero, bus.Busy, bus.Done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   op;
    logic [W-1:0] a, b;
    m = '0;
    bus.Start = 1'b0; bus.Opcode = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset_state");
    reset_n = 1'b1;

    run_op(OP_ADD,   16'h7FFF, 16'h0001, 1'b0);
    run_op(OP_ADDU,  16'hFFFF, 16'h0001, 1'b0);
    run_op(OP_ADDCU, 16'h0000, 16'h0000, 1'b0);
    run_op(OP_LSH,   16'h0001, 16'd5,    1'b1);
    run_op(OP_ARSH,  16'h8000, 16'd20,   1'b0);
    run_op(OP_SUB,   16'h0001, 16'h0002, 1'b0);
    run_op(OP_CMP,   16'd5,    16'd5,    1'b0);
    run_op(OP_MUL,   16'h0100, 16'h0100, 1'b0);
    run_op(OP_NOP,   16'h1234, 16'h5678, 1'b0);
    run_op(8'hFF,    16'h1234, 16'h5678, 1'b0);
    run_op(OP_RSH,   16'hA5A5, 16'd0,    1'b0);
    run_op(OP_RSH,   16'h8000, 16'd15,   1'b0);
    run_op(OP_ARSH,  16'h8001, 16'd15,   1'b0);
    run_op(OP_LSH,   16'hFFFF, 16'd16,   1'b0);
    run_op(OP_ALSH,  16'h0003, 16'd1,    1'b0);

    // reset in the 4th busy cycle of a 10-step right shift
    bus.Start = 1'b1; bus.Opcode = OP_RSH; bus.A = 16'hF0F0; bus.B = 16'd10;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_cleared("reset_abort");
    m = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset_hold");
    reset_n = 1'b1;
    run_op(OP_ADD, 16'h0002, 16'h0003, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = op_tab[$urandom_range(0, 22)];
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if (op >= OP_LSH && op <= OP_ARSH && $urandom_range(0, 3) != 0)
        b = W'($urandom_range(0, 20));
      run_op(op, a, b, (op >= OP_LSH && op <= OP_ARSH && b >= 3 && b < W) ? 1'b1 : 1'b0);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending responses expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
